structure_hazard_seq: RTL
=========================

STRUCTURE_HAZARD_SEQ -- requirements
Module: structure_hazard_seq

Interface
REQ-001 SHALL have parameter MEM_LAT, default 2, data-memory access latency in cycles (legal 1..255).
REQ-002 SHALL have parameter STAT_W, default 16, width of the stall statistics counter.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rest  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports lwi, swi, add  input  1 each  special memory-memory op present in the MEM stage.
REQ-006 SHALL have ports mem_read, mem_write  input  1 each  ordinary data-memory access in the MEM stage.
REQ-007 SHALL have port mem_ready  input  1  data memory access complete; used only under MEM_READY_EN.
REQ-008 SHALL have port ctrl_sel  output  2  datapath select: 3 normal, 2 lwi, 1 swi, 0 add.
REQ-009 SHALL have port alu_result_mux  output  1  1 selects the normal ALU path, 0 selects the special path.
REQ-010 SHALL have ports power_freeze_pc, freeze_pc, freeze_ifid, flush_ifid, freeze_idex, special_exmem, freeze_memwb  output  1 each  pipeline control.
REQ-011 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.
REQ-012 SHALL have port stall_cycles  output  STAT_W  saturating count of frozen cycles.

Function
REQ-013 SHALL implement FSM states IDLE, SPEC_PH1, SPEC_PH2, MEM_WAIT.
REQ-014 SHALL decode special ops in IDLE with priority lwi > swi > add, and latch the winning code for the whole sequence.
REQ-015 SHALL be a "trigger cycle": an IDLE cycle in which lwi|swi|add is high. In that cycle (Mealy) it SHALL assert every freeze, power_freeze_pc and special_exmem, drive alu_result_mux=0 and drive ctrl_sel from the decode; next state SPEC_PH1.
REQ-016 SHALL hold SPEC_PH1 for MEM_LAT cycles, then SPEC_PH2 for MEM_LAT cycles, then return to IDLE. Outputs SHALL stay as in REQ-015 using the latched code. Total assertion is 1+2*MEM_LAT cycles.
REQ-017 SHALL, on an IDLE cycle with mem_read|mem_write and no special op, assert freeze_pc and flush_ifid. If MEM_LAT>1 it SHALL go to MEM_WAIT for MEM_LAT-1 cycles with the same outputs; if MEM_LAT=1 it SHALL stay in IDLE.
REQ-018 SHALL give a special op priority when a special op and mem_read/mem_write coincide, with flush_ifid=0.
REQ-019 SHALL ignore all triggers outside IDLE.
REQ-020 SHALL drive normal outputs whenever IDLE with no trigger: ctrl_sel=3, alu_result_mux=1, all freeze/flush/special=0.
REQ-021 SHALL use a phase counter of width $clog2(MEM_LAT+1) that clears on every state entry and never wraps.
REQ-022 SHALL increment stall_cycles on every cycle freeze_pc=1 and saturate at all-ones.

Reset
REQ-023 SHALL, while rest=1, force normal outputs combinationally. On the next edge it SHALL set state=IDLE, phase counter=0, latched code=3 and stall_cycles=0.
REQ-024 SHALL abort any sequence on reset mid-operation without completing its remaining phases.

Configuration
REQ-025 SHALL support macro STRUCT_HAZARD_MEM_READY_EN. When defined, each SPEC phase and MEM_WAIT SHALL end on the cycle mem_ready=1 (inclusive), with no upper bound, and the counter SHALL be unused. When undefined, mem_ready SHALL be ignored and the fixed MEM_LAT timing applies.

Structure
REQ-026 SHALL place the state enum and the ctrl_sel codes CTRL_ADD=0, CTRL_SWI=1, CTRL_LWI=2, CTRL_NORMAL=3 in package structure_hazard_pkg.
REQ-027 SHALL implement the phase counter as sub-module hazard_lat_counter (inputs clear and enable; output done).

Verification
REQ-028 SHALL cover: MEM_LAT=2, lwi pulse 1 cycle -> ctrl_sel=2, alu_result_mux=0, freezes high exactly 5 cycles, then normal.
REQ-029 SHALL cover: lwi=swi=add=1 together -> ctrl_sel=2 throughout; swi alone -> 1; add alone -> 0.
REQ-030 SHALL cover: MEM_LAT=1, mem_read 1 cycle -> freeze_pc=flush_ifid=1 for 1 cycle only; MEM_LAT=3 -> 3 cycles, busy high for 2.
REQ-031 SHALL cover: add and mem_write in the same cycle -> special sequence, flush_ifid=0.
REQ-032 SHALL cover: rest asserted in the second SPEC_PH1 cycle -> outputs normal that cycle, IDLE next, stall_cycles=0.
REQ-033 SHALL cover: MEM_READY_EN defined, swi, mem_ready high after 4 then 1 cycles -> freezes high 1+4+1 cycles.

Source files
------------

// File: rtl/structure_hazard_pkg.sv
// Shared types and constants for the structural-hazard sequencer.
//   state_e        : sequencer FSM states
//   CTRL_*         : datapath select codes driven on ctrl_sel
//   decode_special : priority decode of the special memory-memory ops (lwi > swi > add)
package structure_hazard_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StSpecPh1 = 2'd1,
    StSpecPh2 = 2'd2,
    StMemWait = 2'd3
  } state_e;

  localparam logic [1:0] CTRL_ADD    = 2'd0;
  localparam logic [1:0] CTRL_SWI    = 2'd1;
  localparam logic [1:0] CTRL_LWI    = 2'd2;
  localparam logic [1:0] CTRL_NORMAL = 2'd3;

  function automatic logic [1:0] decode_special(input logic lwi, input logic swi,
                                                input logic add);
    logic [1:0] code;
    code = CTRL_NORMAL;
    if (lwi) begin
      code = CTRL_LWI;
    end else if (swi) begin
      code = CTRL_SWI;
    end else if (add) begin
      code = CTRL_ADD;
    end
    return code;
  endfunction

endpackage

// File: rtl/hazard_lat_counter.sv
// Phase counter for the structural-hazard sequencer.
// Counts cycles spent in the current FSM state; done is high while the count equals limit.
// The count stops at limit, so it never wraps.
//   clk    : clock
//   rest   : synchronous active-high reset
//   clear  : restart the count at zero (state entry)
//   enable : advance the count this cycle
//   limit  : terminal count for the current state
//   done   : count has reached limit
module hazard_lat_counter #(
  parameter int unsigned Width = 2
) (
  input  logic             clk,
  input  logic             rest,
  input  logic             clear,
  input  logic             enable,
  input  logic [Width-1:0] limit,
  output logic             done
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != limit)) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rest) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == limit);

endmodule

// File: rtl/structure_hazard_seq.sv
// Structural-hazard sequencer for a pipeline with memory-memory special ops (lwi/swi/add).
// A special op in IDLE runs a trigger cycle plus two MEM_LAT-long phases with the whole
// pipeline frozen and the special datapath selected. An ordinary data-memory access freezes
// the PC and flushes IF/ID for MEM_LAT cycles in total.
// Optional build macro STRUCT_HAZARD_MEM_READY_EN: phases and the memory wait end on the
// cycle mem_ready is high instead of after a fixed MEM_LAT count.
//   clk, rest                    : clock, synchronous active-high reset
//   lwi, swi, add                : special op present in MEM stage
//   mem_read, mem_write          : ordinary data-memory access in MEM stage
//   mem_ready                    : memory access complete (ready-handshake build only)
//   ctrl_sel, alu_result_mux     : datapath selects
//   power_freeze_pc .. freeze_memwb : pipeline freeze / flush controls
//   busy                         : FSM not in IDLE
//   stall_cycles                 : saturating count of cycles with freeze_pc high
module structure_hazard_seq
  import structure_hazard_pkg::*;
#(
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned STAT_W  = 16
) (
  input  logic              clk,
  input  logic              rest,
  input  logic              lwi,
  input  logic              swi,
  input  logic              add,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              mem_ready,
  output logic [1:0]        ctrl_sel,
  output logic              alu_result_mux,
  output logic              power_freeze_pc,
  output logic              freeze_pc,
  output logic              freeze_ifid,
  output logic              flush_ifid,
  output logic              freeze_idex,
  output logic              special_exmem,
  output logic              freeze_memwb,
  output logic              busy,
  output logic [STAT_W-1:0] stall_cycles
);

  localparam int unsigned CntW    = $clog2(MEM_LAT + 1);
  localparam int unsigned PhLim   = MEM_LAT - 1;
  // MEM_WAIT covers MEM_LAT-1 cycles after the trigger cycle; unused when MEM_LAT is 1.
  localparam int unsigned WaitLim = (MEM_LAT > 1) ? (MEM_LAT - 2) : 0;

  state_e            state_q, state_d;
  logic [1:0]        code_q, code_d;
  logic [STAT_W-1:0] stall_q, stall_d;

  logic            special_op;
  logic            mem_op;
  logic            cnt_clear;
  logic            cnt_enable;
  logic [CntW-1:0] cnt_limit;
  logic            cnt_done;
  logic            phase_done;

  assign special_op = lwi | swi | add;
  assign mem_op     = (mem_read | mem_write) & ~special_op;

  // Clearing on any state change restarts the count on every state entry.
  assign cnt_clear  = rest | (state_d != state_q);
  assign cnt_enable = (state_q != StIdle);
  assign cnt_limit  = (state_q == StMemWait) ? CntW'(WaitLim) : CntW'(PhLim);

  hazard_lat_counter #(
    .Width (CntW)
  ) u_lat_counter (
    .clk    (clk),
    .rest   (rest),
    .clear  (cnt_clear),
    .enable (cnt_enable),
    .limit  (cnt_limit),
    .done   (cnt_done)
  );

`ifdef STRUCT_HAZARD_MEM_READY_EN
  logic unused_cnt_done;
  assign unused_cnt_done = cnt_done;
  assign phase_done      = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign phase_done       = cnt_done;
`endif

  always_comb begin
    state_d         = state_q;
    code_d          = code_q;
    ctrl_sel        = CTRL_NORMAL;
    alu_result_mux  = 1'b1;
    power_freeze_pc = 1'b0;
    freeze_pc       = 1'b0;
    freeze_ifid     = 1'b0;
    flush_ifid      = 1'b0;
    freeze_idex     = 1'b0;
    special_exmem   = 1'b0;
    freeze_memwb    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (special_op) begin
          code_d   = decode_special(lwi, swi, add);
          ctrl_sel = code_d;
          state_d  = StSpecPh1;
        end else if (mem_op) begin
          freeze_pc  = 1'b1;
          flush_ifid = 1'b1;
          if (MEM_LAT > 1) begin
            state_d = StMemWait;
          end
        end
      end
      StSpecPh1: begin
        ctrl_sel = code_q;
        if (phase_done) begin
          state_d = StSpecPh2;
        end
      end
      StSpecPh2: begin
        ctrl_sel = code_q;
        if (phase_done) begin
          state_d = StIdle;
        end
      end
      StMemWait: begin
        freeze_pc  = 1'b1;
        flush_ifid = 1'b1;
        if (phase_done) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Every cycle of a special sequence, including the trigger cycle, freezes the pipeline.
    if ((state_q == StSpecPh1) || (state_q == StSpecPh2) ||
        ((state_q == StIdle) && special_op)) begin
      alu_result_mux  = 1'b0;
      power_freeze_pc = 1'b1;
      freeze_pc       = 1'b1;
      freeze_ifid     = 1'b1;
      freeze_idex     = 1'b1;
      special_exmem   = 1'b1;
      freeze_memwb    = 1'b1;
    end

    // Reset overrides the outputs combinationally in the same cycle.
    if (rest) begin
      ctrl_sel        = CTRL_NORMAL;
      alu_result_mux  = 1'b1;
      power_freeze_pc = 1'b0;
      freeze_pc       = 1'b0;
      freeze_ifid     = 1'b0;
      flush_ifid      = 1'b0;
      freeze_idex     = 1'b0;
      special_exmem   = 1'b0;
      freeze_memwb    = 1'b0;
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (freeze_pc && (stall_q != {STAT_W{1'b1}})) begin
      stall_d = stall_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rest) begin
      state_q <= StIdle;
      code_q  <= CTRL_NORMAL;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      stall_q <= stall_d;
    end
  end

  assign busy         = (state_q != StIdle);
  assign stall_cycles = stall_q;

endmodule
